// File: rtl/mem_pkg.sv
// Shared definitions for the PDP-8/e main-memory controller: op codes,
// controller state encodings and the parity generator.
package mem_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_INC   = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_CLEAR = 3'd0,
    ST_IDLE  = 3'd1,
    ST_RD1   = 3'd2,
    ST_RD2   = 3'd3,
    ST_WB    = 3'd4,
    ST_WR    = 3'd5
  } state_e;

  // Odd parity bit for a data word zero-extended to 32 bits; the stored
  // word {par, data} then always has an odd number of ones.
  function automatic logic odd_par(input logic [31:0] d);
    return ~(^d);
  endfunction

endpackage

// File: rtl/mem_array_sp.sv
// Single-port synchronous RAM with registered read data. A read issued in
// the same cycle as a write to that address returns the old contents.
module mem_array_sp #(
  parameter int AW = 15,
  parameter int DW = 13
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  // Block-RAM template: optional write, unconditional registered read.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_ctrl_rmw.sv
// PDP-8/e main-memory controller: req/ready/ack handshake, atomic
// read-increment-write, per-word odd parity and a post-reset clear sweep.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_CLEAR | sweeping every address to 0 (with good parity)
//  ST_IDLE  | waiting for req && ready
//  ST_RD1   | array read issued at addr_q
//  ST_RD2   | read data valid; READ completes, INC computes sum
//  ST_WB    | INC sum written back, ack
//  ST_WR    | WRITE data written, ack
module mem_ctrl_rmw
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH     = 15,
  parameter int DATA_WIDTH     = 12,
  parameter int PARITY         = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req,
  input  logic [1:0]            op,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  ready,
  output logic                  ack,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  zero,
  output logic                  parity_err,
  output logic                  clr_busy
);

  localparam int MW = DATA_WIDTH + PARITY;

  state_e                state;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] din_q;
  logic [DATA_WIDTH-1:0] sum_q;
  logic                  inc_q;
  logic                  perr_q;

  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [MW-1:0]         ram_wdata;
  logic [MW-1:0]         ram_rdata;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_perr;

  // Array port steering: the sweep, WRITE and INC write-back share the one port.
  always_comb begin
    ram_we   = 1'b0;
    ram_addr = addr_q;
    wr_data  = din_q;
    case (state)
      ST_CLEAR: begin
        ram_we   = 1'b1;
        ram_addr = clr_cnt;
        wr_data  = '0;
      end
      ST_WR: ram_we = 1'b1;
      ST_WB: begin
        ram_we  = 1'b1;
        wr_data = sum_q;
      end
      default: ;
    endcase
  end

  assign rd_data = ram_rdata[DATA_WIDTH-1:0];

  if (PARITY != 0) begin : g_par
    assign ram_wdata = {odd_par(32'(wr_data)), wr_data};
    // A good word has odd weight over parity+data.
    assign rd_perr   = ~(^ram_rdata);
  end else begin : g_nopar
    assign ram_wdata = wr_data;
    assign rd_perr   = 1'b0;
  end

  mem_array_sp #(
    .AW (ADDR_WIDTH),
    .DW (MW)
  ) u_array (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Controller FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      clr_busy   <= (CLEAR_ON_RESET != 0);
      clr_cnt    <= '0;
      ready      <= 1'b0;
      ack        <= 1'b0;
      dout       <= '0;
      zero       <= 1'b0;
      parity_err <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      sum_q      <= '0;
      inc_q      <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      ack <= 1'b0;
      case (state)
        ST_CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == '1) begin
            clr_busy <= 1'b0;
            ready    <= 1'b1;
            state    <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          // ready comes up one cycle late when leaving reset without a sweep
          if (req && ready) begin
            addr_q <= addr;
            din_q  <= din;
            inc_q  <= (op == OP_INC);
            ready  <= 1'b0;
            state  <= (op == OP_WRITE) ? ST_WR : ST_RD1;
          end else begin
            ready <= 1'b1;
          end
        end
        ST_RD1: state <= ST_RD2;
        ST_RD2: begin
          if (inc_q) begin
            sum_q  <= rd_data + 1'b1;
            perr_q <= rd_perr;
            state  <= ST_WB;
          end else begin
            ack        <= 1'b1;
            dout       <= rd_data;
            zero       <= 1'b0;
            parity_err <= rd_perr;
            ready      <= 1'b1;
            state      <= ST_IDLE;
          end
        end
        ST_WB: begin
          ack        <= 1'b1;
          dout       <= sum_q;
          zero       <= (sum_q == '0);
          parity_err <= perr_q;
          ready      <= 1'b1;
          state      <= ST_IDLE;
        end
        ST_WR: begin
          ack        <= 1'b1;
          dout       <= din_q;
          zero       <= 1'b0;
          parity_err <= 1'b0;
          ready      <= 1'b1;
          state      <= ST_IDLE;
        end
        default: begin
          ready <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl_rmw.sv
// Directed bench for mem_ctrl_rmw with an 8K-word array.
module tb_mem_ctrl_rmw;

  localparam int AW = 13;
  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          req;
  logic [1:0]    op;
  logic [AW-1:0] addr;
  logic [DW-1:0] din;
  logic          ready;
  logic          ack;
  logic [DW-1:0] dout;
  logic          zero;
  logic          parity_err;
  logic          clr_busy;

  int n_cmp = 0;
  int n_err = 0;

  mem_ctrl_rmw #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .PARITY         (1),
    .CLEAR_ON_RESET (1)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req),
    .op         (op),
    .addr       (addr),
    .din        (din),
    .ready      (ready),
    .ack        (ack),
    .dout       (dout),
    .zero       (zero),
    .parity_err (parity_err),
    .clr_busy   (clr_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0o expected %0o", tag, obs, exp);
    end
  endtask

  // Count cycles of clr_busy from the current negedge; requests held
  // during the sweep must be ignored.
  task automatic wait_clear(input string tag);
    int n;
    int stray;
    n = 0;
    stray = 0;
    req  = 1'b1;
    op   = 2'b01;
    addr = 13'o300;
    din  = 12'o1111;
    while (clr_busy === 1'b1 && n < 9000) begin
      @(negedge clk);
      n++;
      if (ack === 1'b1) stray++;
    end
    req = 1'b0;
    chk({tag, "_cycles"}, 32'(n), 32'd8192);
    chk({tag, "_ready"}, 32'(ready), 32'd1);
    chk({tag, "_stray_ack"}, 32'(stray), 32'd0);
  endtask

  // Issue one request at a negedge and check latency and results.
  task automatic do_op(input string tag, input logic [1:0] o, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input int lat, input logic [DW-1:0] exp_d,
                       input logic exp_z, input logic exp_p);
    int n;
    chk({tag, "_ready"}, 32'(ready), 32'd1);
    req  = 1'b1;
    op   = o;
    addr = a;
    din  = d;
    @(negedge clk);
    req  = 1'b0;
    addr = '1;
    din  = '1;
    op   = 2'b01;
    n = 0;
    while (ack !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'(lat));
    chk({tag, "_dout"}, 32'(dout), 32'(exp_d));
    chk({tag, "_zero"}, 32'(zero), 32'(exp_z));
    chk({tag, "_perr"}, 32'(parity_err), 32'(exp_p));
  endtask

  initial begin
    logic [DW-1:0] obs [4];
    logic [AW-1:0] s_addr [4];
    logic [1:0]    s_op [4];
    logic [DW-1:0] s_din [4];
    int idx, acks, cyc, last_cyc;
    logic accept_now;

    reset_n = 1'b0;
    req  = 1'b0;
    op   = 2'b00;
    addr = '0;
    din  = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_clr_busy", 32'(clr_busy), 32'd1);
    reset_n = 1'b1;

    // 1: sweep length, then cleared contents
    wait_clear("clear1");
    do_op("rd_7777", 2'b00, 13'o7777, 12'o0, 2, 12'o0, 1'b0, 1'b0);
    do_op("rd_0300", 2'b00, 13'o300, 12'o0, 2, 12'o0, 1'b0, 1'b0);

    // 2: write then read back
    do_op("wr_0200", 2'b01, 13'o200, 12'o5432, 1, 12'o5432, 1'b0, 1'b0);
    do_op("rd_0200", 2'b00, 13'o200, 12'o0, 2, 12'o5432, 1'b0, 1'b0);

    // 3: INC wrap to zero, and ordinary INC
    do_op("wr_0010", 2'b01, 13'o10, 12'o7777, 1, 12'o7777, 1'b0, 1'b0);
    do_op("inc_0010", 2'b10, 13'o10, 12'o0, 3, 12'o0, 1'b1, 1'b0);
    do_op("rd_0010", 2'b00, 13'o10, 12'o0, 2, 12'o0, 1'b0, 1'b0);
    do_op("wr_0011", 2'b01, 13'o11, 12'o1234, 1, 12'o1234, 1'b0, 1'b0);
    do_op("inc_0011", 2'b10, 13'o11, 12'o0, 3, 12'o1235, 1'b0, 1'b0);
    do_op("rd3_0011", 2'b11, 13'o11, 12'o0, 2, 12'o1235, 1'b0, 1'b0);

    // 4: corrupted parity detected on READ and INC; INC repairs it
    do_op("wr_0020", 2'b01, 13'o20, 12'o0123, 1, 12'o0123, 1'b0, 1'b0);
    dut.u_array.mem[13'o20][12] = ~dut.u_array.mem[13'o20][12];
    do_op("rd_bad", 2'b00, 13'o20, 12'o0, 2, 12'o0123, 1'b0, 1'b1);
    do_op("inc_bad", 2'b10, 13'o20, 12'o0, 3, 12'o0124, 1'b0, 1'b1);
    do_op("rd_fixed", 2'b00, 13'o20, 12'o0, 2, 12'o0124, 1'b0, 1'b0);

    // 5: back-to-back stream with req held high
    s_op[0] = 2'b01; s_addr[0] = 13'o300; s_din[0] = 12'o0042;
    s_op[1] = 2'b00; s_addr[1] = 13'o300; s_din[1] = 12'o7777;
    s_op[2] = 2'b10; s_addr[2] = 13'o300; s_din[2] = 12'o7777;
    s_op[3] = 2'b00; s_addr[3] = 13'o300; s_din[3] = 12'o7777;
    for (int i = 0; i < 4; i++) obs[i] = '1;
    idx = 0; acks = 0; cyc = 0; last_cyc = 0;
    req = 1'b1; op = s_op[0]; addr = s_addr[0]; din = s_din[0];
    while (acks < 4 && cyc < 40) begin
      accept_now = req && ready;
      @(negedge clk);
      cyc++;
      if (accept_now) begin
        idx++;
        if (idx < 4) begin
          op = s_op[idx]; addr = s_addr[idx]; din = s_din[idx];
        end else begin
          req = 1'b0;
        end
      end
      if (ack === 1'b1) begin
        obs[acks] = dout;
        acks++;
        last_cyc = cyc;
      end
    end
    req = 1'b0;
    chk("b2b_acks", 32'(acks), 32'd4);
    chk("b2b_cycles", 32'(last_cyc), 32'd12);
    chk("b2b_d0", 32'(obs[0]), 32'(12'o0042));
    chk("b2b_d1", 32'(obs[1]), 32'(12'o0042));
    chk("b2b_d2", 32'(obs[2]), 32'(12'o0043));
    chk("b2b_d3", 32'(obs[3]), 32'(12'o0043));
    @(negedge clk);
    chk("b2b_ack_drop", 32'(ack), 32'd0);

    // 6: reset during INC read phase
    op = 2'b10; addr = 13'o11; din = '0; req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(ready), 32'd0);
    chk("mid_rst_ack", 32'(ack), 32'd0);
    chk("mid_rst_dout", 32'(dout), 32'd0);
    chk("mid_rst_zero", 32'(zero), 32'd0);
    chk("mid_rst_perr", 32'(parity_err), 32'd0);
    chk("mid_rst_clr_busy", 32'(clr_busy), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    wait_clear("clear2");
    do_op("rd_after", 2'b00, 13'o300, 12'o0, 2, 12'o0, 1'b0, 1'b0);
    do_op("rd_0200_clr", 2'b00, 13'o200, 12'o0, 2, 12'o0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
